// File: rtl/adv_ddr_serializer.sv
// Pixel FIFO plus DDR/SDR output serializer for the ADV HDMI transmitter, clocked by clk_ddr.
// Optional macro ADV_DDR_STATS_EN adds a saturating underflow_count output.
module adv_ddr_serializer #(
    parameter int DATA_W     = 24,
    parameter int RATIO      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_ddr,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_de,
    input  logic              in_hs,
    input  logic              in_vs,
    input  logic              mode_sdr,
    input  logic              swap,
    output logic              clk_pixel_out,
    output logic              de_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic [DATA_W-1:0] data_out,
    output logic              underflow
`ifdef ADV_DDR_STATS_EN
    ,
    output logic [15:0]       underflow_count
`endif
);

    localparam int HALF_W  = DATA_W / 2;
    localparam int PW      = $clog2(RATIO);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_W + 3;

    // Handshake: a word is accepted on any clk_ddr edge where in_valid && in_ready;
    // while in_ready is low the source holds in_valid and in_data unchanged.

    logic [PW-1:0]      phase;
    logic               edge_a;
    logic               edge_b;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;

    logic [ENTRY_W-1:0] head;
    logic [DATA_W-1:0]  head_data;
    logic [HALF_W-1:0]  head_lo;
    logic [HALF_W-1:0]  head_hi;

    logic               hold_valid;
    logic               hold_sdr;
    logic [HALF_W-1:0]  hold_second;

    assign edge_a = (phase == PW'(RATIO - 1));
    assign edge_b = (phase == PW'(RATIO / 2 - 1));

    always_ff @(posedge clk_ddr) begin
        if (reset || edge_a) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Extra pointer MSB distinguishes full from empty; empty is purely registered, so no bypass.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !reset && !full;
    assign push     = in_valid && in_ready;
    assign pop      = edge_a && !empty;

    always_ff @(posedge clk_ddr) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_vs, in_hs, in_de, in_data};
        end
    end

    always_ff @(posedge clk_ddr) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_data = head[DATA_W-1:0];
    assign head_lo   = head_data[HALF_W-1:0];
    assign head_hi   = head_data[DATA_W-1:HALF_W];

    always_ff @(posedge clk_ddr) begin
        if (reset) begin
            clk_pixel_out <= 1'b0;
            de_out        <= 1'b0;
            hsync_out     <= 1'b0;
            vsync_out     <= 1'b0;
            data_out      <= '0;
            underflow     <= 1'b0;
            hold_valid    <= 1'b0;
            hold_sdr      <= 1'b0;
            hold_second   <= '0;
        end else begin
            underflow <= 1'b0;
            if (edge_a) begin
                clk_pixel_out <= 1'b1;
                if (!empty) begin
                    hold_valid  <= 1'b1;
                    hold_sdr    <= mode_sdr;
                    hold_second <= swap ? head_lo : head_hi;
                    de_out      <= head[DATA_W];
                    hsync_out   <= head[DATA_W+1];
                    vsync_out   <= head[DATA_W+2];
                    data_out    <= mode_sdr ? head_data
                                            : {{HALF_W{1'b0}}, (swap ? head_hi : head_lo)};
                end else begin
                    // Syncs keep their level through a starved slot; only de and data drop.
                    underflow  <= 1'b1;
                    hold_valid <= 1'b0;
                    de_out     <= 1'b0;
                    data_out   <= '0;
                end
            end else if (edge_b) begin
                clk_pixel_out <= 1'b0;
                if (hold_valid && !hold_sdr) begin
                    data_out <= {{HALF_W{1'b0}}, hold_second};
                end
            end
        end
    end

`ifdef ADV_DDR_STATS_EN
    always_ff @(posedge clk_ddr) begin
        if (reset) begin
            underflow_count <= '0;
        end else if (edge_a && empty && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule
